// File: rtl/and_8bit_unit_pkg.sv
// rtl/and_8bit_unit_pkg.sv - shared ALU constants, opcodes and result-flag type
package and_8bit_unit_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_CNT_W = $clog2(ALU_WIDTH + 1);

  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_AND = 3'd1,
    ALU_OP_OR  = 3'd2,
    ALU_OP_XOR = 3'd3
  } alu_op_e;

  // Flag bundle shared by the and/or/xor/add units at the default width
  typedef struct packed {
    logic                 zero;
    logic                 ones;
    logic [ALU_CNT_W-1:0] popcnt;
  } alu_flags_t;

endpackage

// File: rtl/and_8bit_unit_popcount_tree.sv
// rtl/and_8bit_unit_popcount_tree.sv - combinational popcount as a balanced adder tree
module popcount_tree #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  // Heap-ordered tree: leaves at N-1..2N-2, padded with zeros up to a power of two
  localparam int N = 1 << $clog2(WIDTH);

  logic [CNT_W-1:0] node [2*N-1];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_leaf
      if (gi < WIDTH) begin : g_bit
        assign node[N-1+gi] = CNT_W'(data_i[gi]);
      end else begin : g_pad
        assign node[N-1+gi] = '0;
      end
    end
    for (gi = 0; gi < N-1; gi++) begin : g_sum
      assign node[gi] = node[2*gi+1] + node[2*gi+2];
    end
  endgenerate

  assign count_o = node[0];

endmodule

// File: rtl/and_8bit_unit.sv
// rtl/and_8bit_unit.sv - bitwise AND with combinational result and registered result/flags
module and_8bit_unit
  import and_8bit_unit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             ones_q,
  output logic [CNT_W-1:0] popcnt_q
);

  logic [WIDTH-1:0] and_res;
  logic [CNT_W-1:0] pop;

  logic [WIDTH-1:0] res_d,   res_q;
  logic             valid_d, valid_q;
  logic             zero_d,  zero_q_r;
  logic             ones_d,  ones_q_r;
  logic [CNT_W-1:0] pop_d,   pop_q;

  assign and_res = a & b;
  assign out     = and_res;

  popcount_tree #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_popcount_tree (
    .data_i  (and_res),
    .count_o (pop)
  );

  // Without in_valid the result and flags hold; only the valid strobe drops
  always_comb begin
    res_d   = res_q;
    zero_d  = zero_q_r;
    ones_d  = ones_q_r;
    pop_d   = pop_q;
    valid_d = in_valid;
    if (in_valid) begin
      res_d  = and_res;
      zero_d = (and_res == '0);
      ones_d = (and_res == '1);
      pop_d  = pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      valid_q  <= 1'b0;
      zero_q_r <= 1'b0;
      ones_q_r <= 1'b0;
      pop_q    <= '0;
    end else begin
      res_q    <= res_d;
      valid_q  <= valid_d;
      zero_q_r <= zero_d;
      ones_q_r <= ones_d;
      pop_q    <= pop_d;
    end
  end

  assign out_q     = res_q;
  assign out_valid = valid_q;
  assign zero_q    = zero_q_r;
  assign ones_q    = ones_q_r;
  assign popcnt_q  = pop_q;

endmodule

// File: tb/tb_and_8bit_unit.sv
// tb/tb_and_8bit_unit.sv - directed table-driven bench for and_8bit_unit
module tb_and_8bit_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic [7:0] out;
  logic [7:0] out_q;
  logic       out_valid;
  logic       zero_q;
  logic       ones_q;
  logic [3:0] popcnt_q;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_zero;
    logic       exp_ones;
    logic [3:0] exp_pop;
  } vec_t;

  vec_t vecs [10];
  vec_t strm [4];

  and_8bit_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid),
    .zero_q    (zero_q),
    .ones_q    (ones_q),
    .popcnt_q  (popcnt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name, input vec_t v, input logic exp_valid);
    check({name, ".out_q"},     32'(out_q),     32'(v.exp_out));
    check({name, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({name, ".zero_q"},    32'(zero_q),    32'(v.exp_zero));
    check({name, ".ones_q"},    32'(ones_q),    32'(v.exp_ones));
    check({name, ".popcnt_q"},  32'(popcnt_q),  32'(v.exp_pop));
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{8'h00, 8'hD3, 8'h00, 1'b1, 1'b0, 4'd0};
    vecs[2] = '{8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 4'd8};
    vecs[4] = '{8'hAA, 8'hCC, 8'h88, 1'b0, 1'b0, 4'd2};
    vecs[5] = '{8'hEC, 8'h13, 8'h00, 1'b1, 1'b0, 4'd0};
    vecs[6] = '{8'h5A, 8'hF0, 8'h50, 1'b0, 1'b0, 4'd2};
    vecs[7] = '{8'h81, 8'hFF, 8'h81, 1'b0, 1'b0, 4'd2};
    vecs[8] = '{8'h7F, 8'hFF, 8'h7F, 1'b0, 1'b0, 4'd7};
    vecs[9] = '{8'hB7, 8'hF6, 8'hB6, 1'b0, 1'b0, 4'd5};

    strm[0] = '{8'h12, 8'hFF, 8'h12, 1'b0, 1'b0, 4'd2};
    strm[1] = '{8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 4'd2};
    strm[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 4'd8};
    strm[3] = '{8'h0F, 8'h0E, 8'h0E, 1'b0, 1'b0, 4'd3};

    // Reset state, with the combinational path live during reset
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 8'h3C;
    b = 8'h0F;
    #2;
    check("rst.out_comb", 32'(out), 32'h0C);
    @(posedge clk);
    #1;
    check_regs("rst", '{8'h3C, 8'h0F, 8'h00, 1'b0, 1'b0, 4'd0}, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Single captures from the table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = vecs[i].a;
      b = vecs[i].b;
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d.out", i), 32'(out), 32'(vecs[i].exp_out));
      @(posedge clk);
      #1;
      check_regs($sformatf("vec%0d", i), vecs[i], 1'b1);
    end

    // Back-to-back stream: each result appears one edge after its inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = strm[i].a;
      b = strm[i].b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_regs($sformatf("strm%0d", i), strm[i], 1'b1);
    end

    // Dropping in_valid clears only the strobe; result and flags hold
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hFF;
    b = 8'hFF;
    @(posedge clk);
    #1;
    check_regs("hold", strm[3], 1'b0);
    @(posedge clk);
    #1;
    check_regs("hold2", strm[3], 1'b0);

    // Asynchronous reset mid-stream, between edges
    @(negedge clk);
    a = 8'h3C;
    b = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst.out_q", 32'(out_q), 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("async_rst", '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0}, 1'b0);
    check("async_rst.out_comb", 32'(out), 32'h3C);
    @(posedge clk);
    #1;
    check_regs("rst_hold", '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0}, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    a = 8'hC3;
    b = 8'hFF;
    @(posedge clk);
    #1;
    check_regs("resume", '{8'hC3, 8'hFF, 8'hC3, 1'b0, 1'b0, 4'd4}, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
